// File: rtl/array_div_sequential_pkg.sv
// Shared constants and FSM encoding for the sequential 8-by-4 divider.
// DIVIDEND_W / DIVISOR_W set the operand widths; ITER is the number of
// restoring steps (one quotient bit per step).
package array_div_sequential_pkg;

  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 4;
  localparam int ITER       = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/array_div_sequential_step.sv
// div_step_5bit: one combinational restoring-division step.
// Ports:
//   rem_in  [4:0] already-shifted partial remainder {R[3:0], dividend bit}
//   divisor [3:0] unsigned divisor
//   rem_out [4:0] partial remainder after the step
//   q_bit         quotient bit produced by this step (1 = subtract kept)
module div_step_5bit
  import array_div_sequential_pkg::*;
(
  input  logic [DIVISOR_W:0]   rem_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   rem_out,
  output logic                 q_bit
);

  // One extra bit on top of the 5-bit trial acts as the borrow flag.
  logic [DIVISOR_W+1:0] diff;

  always_comb begin
    diff    = {1'b0, rem_in} - {2'b00, divisor};
    q_bit   = ~diff[DIVISOR_W+1];
    rem_out = q_bit ? diff[DIVISOR_W:0] : rem_in;
  end

endmodule

// File: rtl/array_div_sequential.sv
// array_div_sequential: 8-bit by 4-bit unsigned restoring divider, one
// quotient bit per clock, MSB first.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   start               request; only looked at in IDLE
//   dividend, divisor   operands, captured on the accepting edge
//   busy                high while a non-zero-divisor division is running
//   done                one-cycle result-valid pulse
//   quotient, remainder results, held until the next completion or reset
//   div_by_zero         last accepted divisor was zero
// Timing (accepting edge N): RUN for 8 cycles, DONE entered at N+8 with the
// results loaded, done pulse in the cycle after N+9, IDLE again after N+9.
// busy and done are registered, so they trail the FSM by one edge. A zero
// divisor goes IDLE->DONE at N and pulses done in the cycle after N+1.
module array_div_sequential
  import array_div_sequential_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  typedef logic [DIVISOR_W:0] rem_t;

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  rem_t                  rem_q, rem_d;
  // Dividend shift register; quotient bits shift in from the bottom, so
  // after the last step it holds the full quotient.
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
  logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
  logic                  dbz_q, dbz_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  rem_t step_rem_in;
  rem_t step_rem_out;
  logic step_q_bit;

  // R[4] is always zero between steps (R < divisor), so the shift simply
  // drops it off the top.
  assign step_rem_in = rem_t'({rem_q, dvd_q[DIVIDEND_W-1]});

  div_step_5bit u_step (
    .rem_in  (step_rem_in),
    .divisor (dvs_q),
    .rem_out (step_rem_out),
    .q_bit   (step_q_bit)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dvd_d = dividend;
          dvs_d = divisor;
          rem_d = '0;
          cnt_d = '0;
          if (divisor != '0) begin
            state_d = ST_RUN;
          end else begin
            state_d     = ST_DONE;
            quotient_d  = '1;
            remainder_d = dividend[DIVISOR_W-1:0];
            dbz_d       = 1'b1;
          end
        end
      end
      ST_RUN: begin
        rem_d = step_rem_out;
        dvd_d = {dvd_q[DIVIDEND_W-2:0], step_q_bit};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(ITER - 1)) begin
          state_d     = ST_DONE;
          quotient_d  = {dvd_q[DIVIDEND_W-2:0], step_q_bit};
          remainder_d = step_rem_out[DIVISOR_W-1:0];
          dbz_d       = 1'b0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // busy spans the RUN cycles plus the DONE-entry cycle, ending exactly
    // as done rises.
    busy_d = (state_d == ST_RUN) || (state_q == ST_RUN);
    done_d = (state_q == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_array_div_sequential.sv
// Self-checking bench for array_div_sequential. Expected results come from
// plain / and % arithmetic; expected timing is counted in clock cycles from
// the accepting edge.
module tb_array_div_sequential;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  array_div_sequential dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  function automatic void ref_div(input logic [7:0] a, input logic [3:0] b,
                                  output logic [7:0] q, output logic [3:0] r,
                                  output logic z);
    if (b == 4'd0) begin
      q = 8'hFF;
      r = a[3:0];
      z = 1'b1;
    end else begin
      q = a / {4'd0, b};
      r = 4'(a % {4'd0, b});
      z = 1'b0;
    end
  endfunction

  // Drives one start pulse and observes the completion; performs no checks.
  task automatic do_div(input logic [7:0] a, input logic [3:0] b,
                        output logic [7:0] q, output logic [3:0] r,
                        output logic z, output int lat, output int busy_n,
                        output logic pulse_ok);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    lat = -1;
    busy_n = 0;
    q = 8'h00;
    r = 4'h0;
    z = 1'b0;
    pulse_ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (busy) busy_n++;
      if (done) begin
        lat = k;
        q = quotient;
        r = remainder;
        z = div_by_zero;
        break;
      end
      @(negedge clk);
    end
    if (lat >= 0) begin
      @(negedge clk);
      pulse_ok = (done == 1'b0) && (quotient == q) && (remainder == r) &&
                 (div_by_zero == z);
    end
    $display("txn a=%0d b=%0d -> q=%0d r=%0d dbz=%0d lat=%0d busy=%0d",
             a, b, q, r, z, lat, busy_n);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    dividend = 8'd0;
    divisor = 4'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags busy=%b done=%b required 0 0", busy, done);
    end
    checks++;
    if (quotient !== 8'd0 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_results q=%h r=%h dbz=%b required 0 0 0",
               quotient, remainder, div_by_zero);
    end
    rst = 1'b0;
  endtask

  task automatic run_and_check(input logic [7:0] a, input logic [3:0] b,
                               input string tag);
    logic [7:0] q, eq;
    logic [3:0] r, er;
    logic z, ez, pok;
    int lat, bn;
    do_div(a, b, q, r, z, lat, bn, pok);
    ref_div(a, b, eq, er, ez);
    checks++;
    if ({q, r, z} !== {eq, er, ez}) begin
      failures++;
      $display("FAIL %s_result a=%0d b=%0d got q=%0d r=%0d dbz=%0d required q=%0d r=%0d dbz=%0d",
               tag, a, b, q, r, z, eq, er, ez);
    end
    checks++;
    if (lat != ((b == 4'd0) ? 1 : 9)) begin
      failures++;
      $display("FAIL %s_latency a=%0d b=%0d got %0d required %0d",
               tag, a, b, lat, (b == 4'd0) ? 1 : 9);
    end
    checks++;
    if (bn != ((b == 4'd0) ? 0 : 9)) begin
      failures++;
      $display("FAIL %s_busy_cycles a=%0d b=%0d got %0d required %0d",
               tag, a, b, bn, (b == 4'd0) ? 0 : 9);
    end
    checks++;
    if (pok !== 1'b1) begin
      failures++;
      $display("FAIL %s_pulse_hold a=%0d b=%0d got done_low_and_held=%b required 1",
               tag, a, b, pok);
    end
  endtask

  task automatic test_directed;
    logic [7:0] a_tab [4] = '{8'd200, 8'd255, 8'd0, 8'd13};
    logic [3:0] b_tab [4] = '{4'd7, 4'd1, 4'd15, 4'd0};
    for (int i = 0; i < 4; i++) run_and_check(a_tab[i], b_tab[i], "directed");
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++)
      run_and_check(8'($urandom), 4'($urandom_range(0, 15)), "random");
  endtask

  task automatic test_ignore_start;
    logic [7:0] eq;
    logic [3:0] er;
    logic ez;
    int k, extra;
    ref_div(8'd100, 4'd3, eq, er, ez);
    @(negedge clk);
    dividend = 8'd100; divisor = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; dividend = 8'($urandom); divisor = 4'($urandom);
    @(negedge clk);
    @(negedge clk);
    dividend = 8'd9; divisor = 4'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 3;
    while (k < 20 && !done) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != 9 || done !== 1'b1) begin
      failures++;
      $display("FAIL ignore_start_latency got %0d required 9", k);
    end
    checks++;
    if ({quotient, remainder, div_by_zero} !== {eq, er, ez}) begin
      failures++;
      $display("FAIL ignore_start_result got q=%0d r=%0d dbz=%0d required q=%0d r=%0d dbz=%0d",
               quotient, remainder, div_by_zero, eq, er, ez);
    end
    extra = 0;
    repeat (14) begin
      @(negedge clk);
      if (done) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL ignore_start_queued got %0d extra done pulses required 0", extra);
    end
    $display("txn a=100 b=3 with ignored start a=9 b=9 -> q=%0d r=%0d", quotient, remainder);
  endtask

  task automatic test_reset_abort;
    int seen;
    @(negedge clk);
    dividend = 8'($urandom); divisor = 4'($urandom_range(1, 15)); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 15'd0) begin
      failures++;
      $display("FAIL abort_outputs busy=%b done=%b q=%h r=%h dbz=%b required all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL abort_quiet got %0d busy/done cycles required 0", seen);
    end
    $display("txn reset abort in RUN cycle 4");
    run_and_check(8'($urandom), 4'($urandom_range(1, 15)), "after_abort");
    run_and_check(8'd250, 4'd11, "after_abort");
  endtask

  task automatic test_back_to_back;
    logic [11:0] v;
    logic [7:0] a_cur, eq;
    logic [3:0] b_cur, er;
    logic ez;
    int k, extra;
    logic got;
    @(negedge clk);
    v = 12'd0;
    a_cur = v[11:4];
    b_cur = v[3:0];
    dividend = a_cur; divisor = b_cur; start = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      k = 0;
      got = 1'b0;
      while (k < 16) begin
        @(negedge clk);
        k++;
        if (done) begin
          got = 1'b1;
          break;
        end
      end
      ref_div(a_cur, b_cur, eq, er, ez);
      checks++;
      if (!got || k != ((b_cur == 4'd0) ? 2 : 10)) begin
        failures++;
        $display("FAIL b2b_period a=%0d b=%0d got %0d cycles (done seen=%b) required %0d",
                 a_cur, b_cur, k, got, (b_cur == 4'd0) ? 2 : 10);
      end
      checks++;
      if ({quotient, remainder, div_by_zero} !== {eq, er, ez}) begin
        failures++;
        $display("FAIL b2b_result a=%0d b=%0d got q=%0d r=%0d dbz=%0d required q=%0d r=%0d dbz=%0d",
                 a_cur, b_cur, quotient, remainder, div_by_zero, eq, er, ez);
      end
      $display("txn b2b a=%0d b=%0d q=%0d r=%0d dbz=%0d", a_cur, b_cur,
               quotient, remainder, div_by_zero);
      if (i < 4095) begin
        v = 12'(i + 1);
        a_cur = v[11:4];
        b_cur = v[3:0];
        dividend = a_cur;
        divisor = b_cur;
      end else begin
        start = 1'b0;
      end
    end
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL b2b_extra_done got %0d required 0", extra);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
